rf_wb_arbiter: RTL and testbench

//  Sole owner of the regfile write port. Arbitrates two writeback sources: A = in-order pipeline ALU result,
//  B = long-latency return (load/div). Registers the granted write into one write stage that drives the regfile.

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_scoreboard.sv | 39 +++
 rtl/rf_wb_arbiter.sv | 113 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and widths for the regfile writeback path.
// Holds the writeback request struct used by the arbiter and write stage.
package rf_pkg;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 1 << AW;

  localparam logic [AW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared when the write enters the write stage, set wins a tie.
// Lookups are combinational from the registered busy vector; x0 never reports busy.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NLK = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           set_vld,
  input  logic [AW-1:0]  set_addr,
  input  logic           clr_vld,
  input  logic [AW-1:0]  clr_addr,
  input  logic [AW-1:0]  lk_addr [NLK],
  output logic [NLK-1:0] lk_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    if (clr_vld) busy_nxt[clr_addr] = 1'b0;
    if (set_vld && set_addr != ZERO_REG) busy_nxt[set_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  always_comb begin
    lk_busy = '0;
    for (int i = 0; i < NLK; i++)
      lk_busy[i] = busy[lk_addr[i]] && (lk_addr[i] != ZERO_REG);
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Regfile write-port owner: B-priority arbiter with A starvation guard, one registered write stage,
// RAW/WAW scoreboard and write-stage forwarding. Grant is combinational and never stalls on the write stage.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_rd,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          rd_busy,
  output logic          fwd1_hit,
  output logic [DW-1:0] fwd1_data,
  output logic          fwd2_hit,
  output logic [DW-1:0] fwd2_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic       a_gnt;
  logic       b_gnt;
  logic [3:0] starve_cnt;
  wb_req_t    sel;
  wb_req_t    ws;

  always_comb begin
    a_gnt = a_valid && (!b_valid || starve_cnt == MAX_CNT);
    b_gnt = b_valid && !a_gnt;
    sel   = '0;
    if (a_gnt)      sel = '{valid: 1'b1, addr: a_addr, data: a_data};
    else if (b_gnt) sel = '{valid: 1'b1, addr: b_addr, data: b_data};
  end

  assign a_ready = a_gnt;
  assign b_ready = b_gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    starve_cnt <= '0;
    else if (!a_valid || a_gnt)   starve_cnt <= '0;
    else if (starve_cnt != MAX_CNT) starve_cnt <= starve_cnt + 4'd1;
  end

  // Address/data hold when idle; only the enable drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws <= '0;
    end else begin
      ws.valid <= sel.valid && (sel.addr != ZERO_REG);
      if (sel.valid) begin
        ws.addr <= sel.addr;
        ws.data <= sel.data;
      end
    end
  end

  assign rf_we    = ws.valid;
  assign rf_waddr = ws.addr;
  assign rf_wdata = ws.data;

  logic [AW-1:0] lk_addr [5];
  logic [4:0]    lk_busy;
  logic          a_busy;
  logic          b_busy;

  assign lk_addr = '{rs1, rs2, iss_rd, a_addr, b_addr};

  rf_scoreboard #(.NLK(5)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_vld  (iss_valid),
    .set_addr (iss_rd),
    .clr_vld  (sel.valid),
    .clr_addr (sel.addr),
    .lk_addr  (lk_addr),
    .lk_busy  (lk_busy)
  );

  assign rs1_busy = lk_busy[0];
  assign rs2_busy = lk_busy[1];
  assign rd_busy  = lk_busy[2];
  assign a_busy   = lk_busy[3];
  assign b_busy   = lk_busy[4];

  assign fwd1_hit  = ws.valid && (ws.addr == rs1) && (rs1 != ZERO_REG);
  assign fwd2_hit  = ws.valid && (ws.addr == rs2) && (rs2 != ZERO_REG);
  assign fwd1_data = ws.data;
  assign fwd2_data = ws.data;

  // Re-issuing a register whose producer writes back on this same edge is legal: set wins.
  assert property (@(posedge clk) disable iff (reset)
    !(iss_valid && rd_busy) || (sel.valid && sel.addr == iss_rd));
  assert property (@(posedge clk) disable iff (reset)
    !a_valid || a_addr == ZERO_REG || a_busy);
  assert property (@(posedge clk) disable iff (reset)
    !b_valid || b_addr == ZERO_REG || b_busy);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: behavioural model checked every negedge plus literal expectations.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_valid, b_valid, iss_valid;
  logic [AW-1:0] a_addr, b_addr, iss_rd, rs1, rs2;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready, rs1_busy, rs2_busy, rd_busy;
  logic          fwd1_hit, fwd2_hit, rf_we;
  logic [DW-1:0] fwd1_data, fwd2_data, rf_wdata;
  logic [AW-1:0] rf_waddr;

  int total = 0;
  int bad   = 0;

  rf_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) u_dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: busy set, outstanding starvation count, and the single write-stage entry.
  bit            m_busy [NREG];
  int            m_starve = 0;
  logic          m_we     = 1'b0;
  logic [AW-1:0] m_waddr  = '0;
  logic [DW-1:0] m_wdata  = '0;

  function automatic logic m_a_wins();
    return a_valid && (!b_valid || m_starve == MAX_WAIT);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) m_busy[i] <= 1'b0;
      m_starve <= 0;
      m_we     <= 1'b0;
      m_waddr  <= '0;
      m_wdata  <= '0;
    end else begin
      if (m_a_wins()) begin
        m_we <= (a_addr != 5'd0); m_waddr <= a_addr; m_wdata <= a_data; m_busy[a_addr] <= 1'b0;
      end else if (b_valid) begin
        m_we <= (b_addr != 5'd0); m_waddr <= b_addr; m_wdata <= b_data; m_busy[b_addr] <= 1'b0;
      end else begin
        m_we <= 1'b0;
      end
      if (!a_valid || m_a_wins()) m_starve <= 0;
      else if (m_starve < MAX_WAIT) m_starve <= m_starve + 1;
      if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chkb("m_a_ready",  a_ready,  m_a_wins());
      chkb("m_b_ready",  b_ready,  b_valid && !m_a_wins());
      chkb("m_rs1_busy", rs1_busy, rs1 != 5'd0 && m_busy[rs1]);
      chkb("m_rs2_busy", rs2_busy, rs2 != 5'd0 && m_busy[rs2]);
      chkb("m_rd_busy",  rd_busy,  iss_rd != 5'd0 && m_busy[iss_rd]);
      chkb("m_rf_we",    rf_we,    m_we);
      chkw("m_rf_waddr", 32'(rf_waddr), 32'(m_waddr));
      chkw("m_rf_wdata", rf_wdata, m_wdata);
      chkb("m_fwd1_hit", fwd1_hit, m_we && m_waddr == rs1 && rs1 != 5'd0);
      chkb("m_fwd2_hit", fwd2_hit, m_we && m_waddr == rs2 && rs2 != 5'd0);
      chkw("m_fwd1_data", fwd1_data, m_wdata);
      chkw("m_fwd2_data", fwd2_data, m_wdata);
      chkw("m_starve",   32'(u_dut.starve_cnt), m_starve);
    end
  end

  task automatic issue(input logic [AW-1:0] r);
    iss_valid = 1'b1;
    iss_rd    = r;
    @(negedge clk);
    @(posedge clk); #1;
    iss_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  bit            exp_b [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [AW-1:0] t2_regs [7] = '{5'd11, 5'd12, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20};

  initial begin
    logic ga, gb;
    reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; iss_valid = 1'b0;
    a_addr = '0; b_addr = '0; iss_rd = '0; rs1 = '0; rs2 = '0;
    a_data = '0; b_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    rs1 = 5'd5; rs2 = 5'd9;
    @(negedge clk);
    chkb("rst_we", rf_we, 1'b0);
    chkw("rst_waddr", 32'(rf_waddr), 32'd0);
    chkw("rst_wdata", rf_wdata, 32'd0);
    chkb("rst_rs1_busy", rs1_busy, 1'b0);
    next_cycle();

    // 1: single A write after issue
    issue(5'd5);
    @(negedge clk);
    chkb("t1_busy_before", rs1_busy, 1'b1);
    next_cycle();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chkb("t1_a_ready", a_ready, 1'b1);
    next_cycle();
    a_valid = 1'b0;
    @(negedge clk);
    chkb("t1_we", rf_we, 1'b1);
    chkw("t1_waddr", 32'(rf_waddr), 32'd5);
    chkw("t1_wdata", rf_wdata, 32'hDEAD_BEEF);
    chkb("t1_fwd1_hit", fwd1_hit, 1'b1);
    chkw("t1_fwd1_data", fwd1_data, 32'hDEAD_BEEF);
    chkb("t1_rs1_busy", rs1_busy, 1'b0);
    next_cycle();
    @(negedge clk);
    chkb("t1_fwd_gone", fwd1_hit, 1'b0);
    next_cycle();

    // 2: both sources held, starvation guard
    for (int i = 0; i < 7; i++) issue(t2_regs[i]);
    a_valid = 1'b1; a_addr = 5'd11; a_data = 32'hA000_0011;
    b_valid = 1'b1; b_addr = 5'd16; b_data = 32'hB000_0016;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chkb("t2_b_gnt", b_ready, exp_b[c]);
      chkb("t2_a_gnt", a_ready, !exp_b[c]);
      if (c == 5) chkw("t2_starve_cleared", 32'(u_dut.starve_cnt), 32'd0);
      ga = a_ready; gb = b_ready;
      next_cycle();
      if (ga) begin a_addr = 5'd12; a_data = 32'hA000_0012; end
      if (gb) begin b_addr = b_addr + 5'd1; b_data = b_data + 32'd1; end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    next_cycle();

    // 3: issue and writeback to the same register on one edge
    issue(5'd7);
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h0000_0077;
    iss_valid = 1'b1; iss_rd = 5'd7; rs1 = 5'd7;
    @(negedge clk);
    chkb("t3_b_ready", b_ready, 1'b1);
    chkb("t3_rd_busy_same", rd_busy, 1'b1);
    next_cycle();
    b_valid = 1'b0; iss_valid = 1'b0;
    @(negedge clk);
    chkb("t3_rd_busy", rd_busy, 1'b1);
    chkb("t3_rs1_busy", rs1_busy, 1'b1);
    chkb("t3_fwd1_hit", fwd1_hit, 1'b1);
    next_cycle();

    // 4: write to x0
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h0000_1234; rs1 = 5'd0; rs2 = 5'd0; iss_rd = 5'd0;
    @(negedge clk);
    chkb("t4_a_ready", a_ready, 1'b1);
    chkb("t4_rs1_busy", rs1_busy, 1'b0);
    next_cycle();
    a_valid = 1'b0;
    @(negedge clk);
    chkb("t4_we", rf_we, 1'b0);
    chkb("t4_fwd1_hit", fwd1_hit, 1'b0);
    next_cycle();

    // 6: back-to-back A writes
    issue(5'd9);
    issue(5'd10);
    rs1 = 5'd9; rs2 = 5'd10;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h9999_0009;
    @(negedge clk);
    chkb("t6_a_ready", a_ready, 1'b1);
    next_cycle();
    a_addr = 5'd10; a_data = 32'hAAAA_0010;
    @(negedge clk);
    chkb("t6_we1", rf_we, 1'b1);
    chkw("t6_waddr1", 32'(rf_waddr), 32'd9);
    chkb("t6_fwd1_hit", fwd1_hit, 1'b1);
    chkw("t6_fwd1_data", fwd1_data, 32'h9999_0009);
    chkb("t6_fwd2_miss", fwd2_hit, 1'b0);
    next_cycle();
    a_valid = 1'b0;
    @(negedge clk);
    chkb("t6_we2", rf_we, 1'b1);
    chkw("t6_waddr2", 32'(rf_waddr), 32'd10);
    chkb("t6_fwd2_hit", fwd2_hit, 1'b1);
    chkw("t6_fwd2_data", fwd2_data, 32'hAAAA_0010);
    chkb("t6_fwd1_miss", fwd1_hit, 1'b0);
    next_cycle();

    // 5: asynchronous reset mid-cycle
    issue(5'd4);
    iss_valid = 1'b1; iss_rd = 5'd3;
    a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h0000_0044; rs1 = 5'd3;
    @(negedge clk);
    next_cycle();
    iss_valid = 1'b0; a_valid = 1'b0;
    #2;
    chkb("t5_pre_busy", rs1_busy, 1'b1);
    chkb("t5_pre_we", rf_we, 1'b1);
    reset = 1'b1;
    #1;
    chkb("t5_busy", rs1_busy, 1'b0);
    chkb("t5_we", rf_we, 1'b0);
    chkw("t5_waddr", 32'(rf_waddr), 32'd0);
    chkw("t5_wdata", rf_wdata, 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
